// File: rtl/fu_result_pipe_pkg.sv
// fu_result_pkg: shared configuration, slot/history records and the register-match helper.
package fu_result_pkg;
    localparam int NUM_FU = 4;
    localparam int MAX_LAT = 8;
    localparam int HIST_DEPTH = 2;
    localparam int DATA_W = 32;
    localparam int REG_W = 5;
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int FU_W = $clog2(NUM_FU);

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic              fmode;
        logic [REG_W-1:0]  rd;
        logic              imm;
        logic [FU_W-1:0]   fu;
        logic [DATA_W-1:0] data;
    } slot_t;

    typedef struct packed {
        logic              valid;
        logic              fmode;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } hist_t;

    function automatic logic same_reg(input logic fa, input logic [REG_W-1:0] ra,
                                      input logic fb, input logic [REG_W-1:0] rb);
        return fa == fb && ra == rb;
    endfunction
endpackage

// File: rtl/fu_result_pipe_if.sv
// fu_result_pipe_if: issue, unit-result, lookup and writeback signals of the result pipe.
interface fu_result_pipe_if;
    import fu_result_pkg::*;
    logic                     issue_valid;
    logic                     issue_ready;
    logic                     issue_wen;
    logic                     issue_fmode;
    logic [REG_W-1:0]         issue_rd;
    logic [LAT_W-1:0]         issue_lat;
    logic [FU_W-1:0]          issue_fu;
    logic [DATA_W-1:0]        issue_data;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic                     flush;
    logic [1:0]               src_fmode;
    logic [2*REG_W-1:0]       src_no;
    logic [1:0]               fwd_hit;
    logic [2*DATA_W-1:0]      fwd_data;
    logic [1:0]               fwd_stall;
    logic                     wb_valid;
    logic                     wb_fmode;
    logic [REG_W-1:0]         wb_rd;
    logic [DATA_W-1:0]        wb_data;
    logic                     busy;

    modport master (
        output issue_valid, issue_wen, issue_fmode, issue_rd, issue_lat, issue_fu, issue_data,
               fu_data, flush, src_fmode, src_no,
        input  issue_ready, fwd_hit, fwd_data, fwd_stall, wb_valid, wb_fmode, wb_rd, wb_data, busy
    );
    modport slave (
        input  issue_valid, issue_wen, issue_fmode, issue_rd, issue_lat, issue_fu, issue_data,
               fu_data, flush, src_fmode, src_no,
        output issue_ready, fwd_hit, fwd_data, fwd_stall, wb_valid, wb_fmode, wb_rd, wb_data, busy
    );
endinterface

// File: rtl/fu_result_pipe_fwd_lookup.sv
// fwd_lookup: youngest-first operand match over pending slots, the writeback register and history.
module fwd_lookup
    import fu_result_pkg::*;
(
    input  logic              src_fmode_i,
    input  logic [REG_W-1:0]  src_no_i,
    input  slot_t             slots_i [1:MAX_LAT],
    input  logic [DATA_W-1:0] s1_data_i,
    input  hist_t             wb_i,
    input  hist_t             hist_i [1:HIST_DEPTH],
    output logic              hit_o,
    output logic              stall_o,
    output logic [DATA_W-1:0] data_o
);
    logic en;
    assign en = src_fmode_i || src_no_i != '0;

    // Scan oldest to youngest so later matches override earlier ones.
    always_comb begin
        hit_o = 1'b0;
        stall_o = 1'b0;
        data_o = '0;
        for (int i = HIST_DEPTH; i >= 1; i--)
            if (en && hist_i[i].valid && same_reg(hist_i[i].fmode, hist_i[i].rd, src_fmode_i, src_no_i)) begin
                hit_o = 1'b1;
                data_o = hist_i[i].data;
            end
        if (en && wb_i.valid && same_reg(wb_i.fmode, wb_i.rd, src_fmode_i, src_no_i)) begin
            hit_o = 1'b1;
            data_o = wb_i.data;
        end
        if (en && slots_i[1].valid && slots_i[1].wen && same_reg(slots_i[1].fmode, slots_i[1].rd, src_fmode_i, src_no_i)) begin
            hit_o = 1'b1;
            data_o = s1_data_i;
        end
        for (int i = 2; i <= MAX_LAT; i++)
            if (en && slots_i[i].valid && slots_i[i].wen && same_reg(slots_i[i].fmode, slots_i[i].rd, src_fmode_i, src_no_i)) begin
                hit_o = 1'b1;
                stall_o = 1'b1;
                data_o = '0;
            end
    end
endmodule

// File: rtl/fu_result_pipe.sv
// fu_result_pipe: in-order result capture from variable-latency units with forwarding and issue hazard checks.
module fu_result_pipe
    import fu_result_pkg::*;
(
    input logic clk,
    input logic rstn,
    fu_result_pipe_if.slave bus
);
    slot_t             s_q [1:MAX_LAT];
    slot_t             s_d [1:MAX_LAT];
    hist_t             hist_q [1:HIST_DEPTH];
    hist_t             wb_q, wb_d;
    slot_t             new_slot;
    logic              eff_wen, strct, waw, accept, busy;
    logic [DATA_W-1:0] s1_data;
    int                lat;

    assign eff_wen = bus.issue_wen && (bus.issue_fmode || bus.issue_rd != '0);
    assign lat = bus.issue_lat == '0 ? 1 : int'(bus.issue_lat);
    assign s1_data = s_q[1].imm ? s_q[1].data : bus.fu_data[int'(s_q[1].fu) * DATA_W +: DATA_W];
    assign new_slot = '{valid: 1'b1, wen: eff_wen, fmode: bus.issue_fmode, rd: bus.issue_rd,
                        imm: bus.issue_lat == '0, fu: bus.issue_fu, data: bus.issue_data};
    assign bus.issue_ready = ~bus.flush && ~strct && ~waw;
    assign accept = bus.issue_valid && bus.issue_ready;

    // S[lat+1] would land in the same slot; older writers still in flight past lat would be overtaken.
    always_comb begin
        strct = 1'b0;
        waw = 1'b0;
        busy = s_q[1].valid;
        for (int i = 2; i <= MAX_LAT; i++) begin
            strct = strct | (i == lat + 1 && s_q[i].valid);
            waw = waw | (eff_wen && i > lat && s_q[i].valid && s_q[i].wen &&
                         same_reg(s_q[i].fmode, s_q[i].rd, bus.issue_fmode, bus.issue_rd));
            busy = busy | s_q[i].valid;
        end
    end

    always_comb begin
        for (int i = 1; i < MAX_LAT; i++) s_d[i] = s_q[i + 1];
        s_d[MAX_LAT] = '0;
        for (int i = 1; i <= MAX_LAT; i++)
            if (bus.flush) s_d[i] = '0;
            else if (accept && i == lat) s_d[i] = new_slot;
    end

    always_comb begin
        wb_d = wb_q;
        wb_d.valid = 1'b0;
        if (!bus.flush && s_q[1].valid)
            wb_d = '{valid: s_q[1].wen, fmode: s_q[1].fmode, rd: s_q[1].rd, data: s1_data};
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            s_q <= '{default: '0};
            wb_q <= '0;
            hist_q <= '{default: '0};
        end else begin
            s_q <= s_d;
            wb_q <= wb_d;
            if (!bus.flush) begin
                hist_q[1] <= wb_q;
                for (int i = 2; i <= HIST_DEPTH; i++) hist_q[i] <= hist_q[i - 1];
            end
        end

    for (genvar j = 0; j < 2; j++) begin : g_fwd
        fwd_lookup u_fwd (
            .src_fmode_i (bus.src_fmode[j]),
            .src_no_i    (bus.src_no[j*REG_W +: REG_W]),
            .slots_i     (s_q),
            .s1_data_i   (s1_data),
            .wb_i        (wb_q),
            .hist_i      (hist_q),
            .hit_o       (bus.fwd_hit[j]),
            .stall_o     (bus.fwd_stall[j]),
            .data_o      (bus.fwd_data[j*DATA_W +: DATA_W])
        );
    end

    assign bus.wb_valid = wb_q.valid;
    assign bus.wb_fmode = wb_q.fmode;
    assign bus.wb_rd = wb_q.rd;
    assign bus.wb_data = wb_q.data;
    assign bus.busy = busy;
endmodule

// File: tb/tb_fu_result_pipe.sv
// tb_fu_result_pipe: directed scenarios plus randomized traffic against an op-list reference model.
module tb_fu_result_pipe;
    import fu_result_pkg::*;

    typedef struct {
        bit        wen;
        bit        fmode;
        bit [4:0]  rd;
        bit        imm;
        int        fu;
        bit [31:0] data;
        int        rem;
    } op_t;
    typedef struct {
        bit        v;
        bit        f;
        bit [4:0]  rd;
        bit [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    op_t pend[$];
    ent_t mwb;
    ent_t mhist[$];

    fu_result_pipe_if bus ();
    fu_result_pipe dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: each in-flight op carries the number of edges left until its result is captured.
    function automatic logic [31:0] fu_word(input int fu);
        return bus.fu_data[fu*DATA_W +: DATA_W];
    endfunction

    function automatic bit m_eff_wen();
        return bus.issue_wen && (bus.issue_fmode || bus.issue_rd != 0);
    endfunction

    function automatic int m_lat();
        return bus.issue_lat == 0 ? 1 : int'(bus.issue_lat);
    endfunction

    function automatic bit m_ready();
        bit ok = !bus.flush;
        foreach (pend[i]) begin
            if (pend[i].rem == m_lat() + 1) ok = 0;
            if (m_eff_wen() && pend[i].wen && pend[i].rem > m_lat() &&
                pend[i].fmode == bus.issue_fmode && pend[i].rd == bus.issue_rd) ok = 0;
        end
        return ok;
    endfunction

    task automatic m_fwd(input int j, output bit hit, output bit stall, output bit [31:0] d);
        bit f = bus.src_fmode[j];
        bit [4:0] r = bus.src_no[j*REG_W +: REG_W];
        int best = -1;
        hit = 0; stall = 0; d = 0;
        if (!f && r == 0) return;
        foreach (pend[i])
            if (pend[i].wen && pend[i].fmode == f && pend[i].rd == r && (best < 0 || pend[i].rem > pend[best].rem)) best = i;
        if (best >= 0) begin
            hit = 1;
            if (pend[best].rem >= 2) stall = 1;
            else d = pend[best].imm ? pend[best].data : fu_word(pend[best].fu);
            return;
        end
        if (mwb.v && mwb.f == f && mwb.rd == r) begin
            hit = 1; d = mwb.d; return;
        end
        foreach (mhist[i])
            if (mhist[i].v && mhist[i].f == f && mhist[i].rd == r) begin
                hit = 1; d = mhist[i].d; return;
            end
    endtask

    task automatic m_reset();
        pend.delete();
        mwb = '{0, 0, 0, 0};
        mhist.delete();
        repeat (HIST_DEPTH) mhist.push_back('{0, 0, 0, 0});
    endtask

    task automatic m_edge();
        op_t np[$];
        ent_t nw;
        bit acc;
        if (bus.flush) begin
            pend.delete();
            mwb.v = 0;
            return;
        end
        acc = bus.issue_valid && m_ready();
        nw = mwb;
        nw.v = 0;
        foreach (pend[i])
            if (pend[i].rem == 1)
                nw = '{pend[i].wen, pend[i].fmode, pend[i].rd, pend[i].imm ? pend[i].data : fu_word(pend[i].fu)};
            else begin
                op_t p = pend[i];
                p.rem--;
                np.push_back(p);
            end
        mhist.push_front(mwb);
        void'(mhist.pop_back());
        mwb = nw;
        if (acc)
            np.push_back('{m_eff_wen(), bus.issue_fmode, bus.issue_rd, bus.issue_lat == 0,
                           int'(bus.issue_fu), bus.issue_data, m_lat()});
        pend = np;
    endtask

    task automatic step();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit wen, input bit fm, input int rd, input int lat, input int fu, input logic [31:0] d);
        bus.issue_valid = v;
        bus.issue_wen = wen;
        bus.issue_fmode = fm;
        bus.issue_rd = REG_W'(rd);
        bus.issue_lat = LAT_W'(lat);
        bus.issue_fu = FU_W'(fu);
        bus.issue_data = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.flush = 0;
    endtask

    task automatic src(input int j, input bit fm, input int rd);
        bus.src_fmode[j] = fm;
        bus.src_no[j*REG_W +: REG_W] = REG_W'(rd);
    endtask

    task automatic drain();
        idle();
        repeat (MAX_LAT + 2) step();
    endtask

    task automatic test_reset();
        idle();
        bus.fu_data = '0;
        src(0, 0, 3);
        src(1, 1, 9);
        m_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        #2;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.issue_ready); end
        checks++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== '0 || bus.wb_rd !== '0) begin errors++; $display("FAIL reset_wb got v%b d%0h r%0d exp 0", bus.wb_valid, bus.wb_data, bus.wb_rd); end
        checks++; if (bus.busy !== 1'b0 || bus.fwd_hit !== 2'b00) begin errors++; $display("FAIL reset_busy_hit got %b/%b exp 0/00", bus.busy, bus.fwd_hit); end
    endtask

    task automatic test_imm();
        drive(1, 1, 0, 3, 0, 0, 32'h11);
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL imm_ready got %b exp 1", bus.issue_ready); end
        step();
        idle();
        #2;
        checks++; if (bus.fwd_hit[0] !== 1'b1 || bus.fwd_stall[0] !== 1'b0 || bus.fwd_data[31:0] !== 32'h11) begin errors++; $display("FAIL imm_fwd_s1 got h%b s%b d%0h exp 1 0 11", bus.fwd_hit[0], bus.fwd_stall[0], bus.fwd_data[31:0]); end
        step();
        #2;
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd3 || bus.wb_data !== 32'h11 || bus.wb_fmode !== 1'b0) begin errors++; $display("FAIL imm_wb got v%b r%0d d%0h exp 1 3 11", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        step();
        #2;
        checks++; if (bus.wb_valid !== 1'b0 || bus.fwd_hit[0] !== 1'b1 || bus.fwd_data[31:0] !== 32'h11) begin errors++; $display("FAIL imm_hist got wbv%b h%b d%0h exp 0 1 11", bus.wb_valid, bus.fwd_hit[0], bus.fwd_data[31:0]); end
    endtask

    task automatic test_latency();
        bus.fu_data = {32'hFFFF0003, 32'h0000ABCD, 32'hFFFF0001, 32'hFFFF0000};
        src(1, 1, 9);
        drive(1, 1, 1, 9, 4, 2, 32'h1234);
        #1;
        checks++; if (bus.issue_ready !== 1'b1 || bus.fwd_hit[1] !== 1'b0) begin errors++; $display("FAIL lat_issue got rdy%b h%b exp 1 0", bus.issue_ready, bus.fwd_hit[1]); end
        step();
        idle();
        for (int e = 0; e < 3; e++) begin
            #2;
            checks++; if (bus.fwd_stall[1] !== 1'b1 || bus.fwd_hit[1] !== 1'b1 || bus.fwd_data[63:32] !== '0) begin errors++; $display("FAIL lat_stall%0d got s%b h%b d%0h exp 1 1 0", e, bus.fwd_stall[1], bus.fwd_hit[1], bus.fwd_data[63:32]); end
            step();
        end
        #2;
        checks++; if (bus.fwd_stall[1] !== 1'b0 || bus.fwd_hit[1] !== 1'b1 || bus.fwd_data[63:32] !== 32'hABCD) begin errors++; $display("FAIL lat_s1 got s%b h%b d%0h exp 0 1 abcd", bus.fwd_stall[1], bus.fwd_hit[1], bus.fwd_data[63:32]); end
        step();
        #2;
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hABCD || bus.wb_rd !== 5'd9 || bus.wb_fmode !== 1'b1) begin errors++; $display("FAIL lat_wb got v%b d%0h r%0d f%b exp 1 abcd 9 1", bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_fmode); end
        drain();
    endtask

    task automatic test_struct();
        drive(1, 1, 0, 10, 3, 1, 0);
        step();
        drive(1, 1, 0, 11, 2, 1, 0);
        #2;
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL struct_reject got %b exp 0", bus.issue_ready); end
        drive(1, 1, 0, 11, 1, 1, 0);
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL struct_lat1 got %b exp 1", bus.issue_ready); end
        step();
        drain();
    endtask

    task automatic test_waw();
        drive(1, 1, 1, 7, 5, 0, 0);
        step();
        drive(1, 1, 1, 7, 1, 0, 0);
        #2;
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL waw_reject got %b exp 0", bus.issue_ready); end
        drive(1, 1, 0, 7, 1, 0, 0);
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL waw_int_ok got %b exp 1", bus.issue_ready); end
        step();
        drain();
    endtask

    task automatic test_r0();
        src(0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 32'h77);
        step();
        idle();
        #2;
        checks++; if (bus.fwd_hit[0] !== 1'b0) begin errors++; $display("FAIL r0_fwd_s1 got %b exp 0", bus.fwd_hit[0]); end
        step();
        #2;
        checks++; if (bus.wb_valid !== 1'b0 || bus.fwd_hit[0] !== 1'b0) begin errors++; $display("FAIL r0_wb got v%b h%b exp 0 0", bus.wb_valid, bus.fwd_hit[0]); end
        drain();
    endtask

    task automatic test_flush();
        int seen = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 12 + k, 6 + k, k, 0);
            #1;
            checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL flush_fill%0d got %b exp 1", k, bus.issue_ready); end
            step();
        end
        drive(1, 1, 0, 15, 1, 0, 32'h99);
        bus.flush = 1;
        #2;
        checks++; if (bus.issue_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL flush_cycle got rdy%b busy%b exp 0 1", bus.issue_ready, bus.busy); end
        step();
        idle();
        #2;
        checks++; if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_after got busy%b wbv%b exp 0 0", bus.busy, bus.wb_valid); end
        repeat (MAX_LAT + 1) begin
            step();
            seen += int'(bus.wb_valid);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_wb got %0d writebacks exp 0", seen); end
    endtask

    task automatic test_random();
        bit hit, stall;
        bit [31:0] d;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, MAX_LAT), $urandom_range(0, NUM_FU - 1), $urandom);
            bus.flush = $urandom_range(0, 24) == 0;
            bus.fu_data = {$urandom, $urandom, $urandom, $urandom};
            for (int j = 0; j < 2; j++) src(j, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            #2;
            checks++; if (bus.issue_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.issue_ready, m_ready()); end
            checks++; if (bus.busy !== (pend.size() != 0)) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, bus.busy, pend.size() != 0); end
            checks++; if (bus.wb_valid !== mwb.v || bus.wb_fmode !== mwb.f || bus.wb_rd !== mwb.rd || bus.wb_data !== mwb.d) begin errors++;
                $display("FAIL rnd_wb c%0d got v%b f%b r%0d d%0h exp v%b f%b r%0d d%0h", c, bus.wb_valid, bus.wb_fmode, bus.wb_rd, bus.wb_data, mwb.v, mwb.f, mwb.rd, mwb.d); end
            for (int j = 0; j < 2; j++) begin
                m_fwd(j, hit, stall, d);
                checks++; if (bus.fwd_hit[j] !== hit || bus.fwd_stall[j] !== stall || bus.fwd_data[j*DATA_W +: DATA_W] !== d) begin errors++;
                    $display("FAIL rnd_fwd%0d c%0d got h%b s%b d%0h exp h%b s%b d%0h", j, c, bus.fwd_hit[j], bus.fwd_stall[j], bus.fwd_data[j*DATA_W +: DATA_W], hit, stall, d); end
            end
            step();
        end
        drain();
    endtask

    task automatic test_async_reset();
        drive(1, 1, 0, 4, 0, 0, 32'h55);
        step();
        drive(1, 1, 0, 5, 5, 1, 0);
        step();
        idle();
        src(0, 0, 4);
        #2;
        checks++; if (bus.wb_data !== 32'h55 || bus.busy !== 1'b1) begin errors++; $display("FAIL arst_pre got d%0h busy%b exp 55 1", bus.wb_data, bus.busy); end
        rstn = 0;
        #1;
        checks++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== '0 || bus.wb_rd !== '0 || bus.busy !== 1'b0 || bus.fwd_hit !== 2'b00) begin errors++;
            $display("FAIL arst_clear got v%b d%0h r%0d busy%b h%b exp all 0", bus.wb_valid, bus.wb_data, bus.wb_rd, bus.busy, bus.fwd_hit); end
        m_reset();
        #1 rstn = 1;
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", bus.issue_ready); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_imm();
        test_latency();
        test_struct();
        test_waw();
        test_r0();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fu_result_pipe.md
Name: fu_result_pipe

Overview:
Parametrised result-tracking pipeline for the execute stage.
- Accepts one issued operation per cycle, each with a per-op latency (0..MAX_LAT) and a functional-unit select.
- Captures each result from the selected unit's data bus on the completion edge, retires results in order of completion through a single writeback port, and keeps a short history for forwarding.
- Provides two forwarding/stall lookups for source operands and rejects issue on writeback-slot collisions or WAW hazards.
- Generalises the fixed-unit, fixed-depth forwarding chain into NUM_FU units, arbitrary latency and configurable history depth.

Parameters:
- NUM_FU, 4, number of functional-unit result buses
- MAX_LAT, 8, largest accepted latency in edges
- HIST_DEPTH, 2, retired results kept for forwarding after wb
- DATA_W, 32, data width
- REG_W, 5, register index width
- derived: LAT_W = $clog2(MAX_LAT+1), FU_W = $clog2(NUM_FU)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- issue_valid  in  1  op offered this cycle
- issue_ready  out  1  op accepted (combinational)
- issue_wen  in  1  op writes a register
- issue_fmode  in  1  1 = float file, 0 = integer file
- issue_rd  in  REG_W  destination register
- issue_lat  in  LAT_W  latency; 0 = immediate data
- issue_fu  in  FU_W  unit select (ignored when lat = 0)
- issue_data  in  DATA_W  result for lat = 0
- fu_data  in  NUM_FU*DATA_W  unit result buses
- flush  in  1  kill all pending ops
- src_fmode  in  2  register file of each lookup
- src_no  in  2*REG_W  register index of each lookup
- fwd_hit  out  2  lookup matched an in-flight or recent result
- fwd_data  out  2*DATA_W  forwarded value
- fwd_stall  out  2  match exists but data is not yet available
- wb_valid  out  1  register write this cycle
- wb_fmode  out  1  write target file
- wb_rd  out  REG_W  write target register
- wb_data  out  DATA_W  write value
- busy  out  1  any pending slot valid

Behaviour:
- Slots S[1..MAX_LAT] each hold: valid, wen, fmode, rd, imm, fu, data. S[k] is captured at the k-th upcoming edge.
- Effective wen = issue_wen && (issue_fmode || issue_rd != 0). Integer r0 is never written or forwarded.
- Slot movement, every edge:
  - S[k] <= S[k+1]; S[MAX_LAT] is cleared.
  - An accepted op with L = max(issue_lat, 1) loads S[L]. Its imm flag is (issue_lat == 0), and its data is issue_data.
- Capture, every edge:
  - If S[1].valid, wb_valid <= S[1].wen.
  - wb_fmode and wb_rd are taken from S[1].
  - wb_data <= imm ? S[1].data : fu_data[S[1].fu].
  - Otherwise wb_valid <= 0 and the other wb fields hold.
  - The wb register shifts into hist[1..HIST_DEPTH].
- Resulting latency:
  - lat 0 and lat 1: wb asserted after the first edge.
  - lat L: fu_data[fu] is sampled at the L-th edge after issue.
- issue_ready = ~flush && ~struct && ~waw.
  - struct: current S[L+1] valid (it would shift into S[L]). For L = MAX_LAT, struct = 0.
  - waw: effective wen set and some valid S[k] with k >= L+1 has wen, the same fmode and the same rd.
- Forwarding lookup (per source, r0 with fmode = 0 never matches). Priority, youngest first: S[MAX_LAT] down to S[2], then S[1], then wb, then hist[1..HIST_DEPTH].
  - Match in S[k], k >= 2: fwd_stall = 1, fwd_hit = 1, fwd_data = 0.
  - Match in S[1]: data is imm ? data : fu_data[fu], combinational, no stall.
  - Match in wb or hist: registered data.
  - No match: fwd_hit = 0, fwd_stall = 0, fwd_data = 0.
  - Only entries with wen set match.
- flush edge:
  - All S[*] are cleared, including S[1], which is not captured. wb_valid <= 0.
  - Issue is ignored.
  - wb fields and history are retained.
- Reset, asynchronous: all slot valids, wb_*, hist and data registers go to 0. issue_ready reads 1 after reset release.
- busy = OR of S[*].valid.

Decomposition:
- Package fu_result_pkg holds:
  - slot_t struct (valid, wen, fmode, rd, imm, fu, data)
  - hist_t struct
  - localparams LAT_W and FU_W
- Sub-module fwd_lookup, instantiated twice: priority match over slots, wb and history. Produces hit, stall and data.

Test Plan:
- Reset with issue lat 0, rd = 3, fmode 0, data 0x11 -> after one edge wb_valid = 1, wb_rd = 3, wb_data = 0x11. One edge later, a src_no = 3 lookup gives hit with data 0x11 from hist[1].
- Issue lat 4 on fu 2 -> a lookup on rd during edges 1-3 gives stall = 1. In the cycle in S[1], fwd_data = fu_data[2] (driven 0xABCD) with stall 0. wb_data = 0xABCD after edge 4.
- Issue lat 3, then lat 2 on the next cycle -> second op rejected (issue_ready = 0, struct). Lat 1 in its place is accepted.
- Issue lat 5 to f7, next cycle lat 1 to f7 -> rejected (waw). The same op to i7 is accepted.
- Issue to rd 0 with fmode 0 and lat 0 -> wb_valid stays 0, and a lookup on 0 gives no hit.
- Three ops pending, assert flush with issue_valid -> busy = 0 next cycle, no further wb_valid, issue dropped. Async rstn low mid-operation -> all outputs 0 immediately.
